ysyx_210247_trap: RTL and testbench

YSYX_210247_TRAP -- requirements
Module: ysyx_210247_trap

---
 rtl/ysyx_210247_trap_pkg.sv | 42 ++++
 rtl/ysyx_210247_trap_if.sv | 39 +++
 rtl/ysyx_210247_csr_file.sv | 88 ++++++++
 rtl/ysyx_210247_trap.sv | 102 ++++++++++
 tb/tb_ysyx_210247_trap.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_210247_trap_pkg.sv
// Shared trap/CSR definitions for the ysyx_210247 core.
// CSR addresses, redirect codes, cause values and bit positions.
package ysyx_210247_trap_pkg;

  localparam int          REG_BUS   = 64;
  localparam logic [63:0] ZERO_WORD = 64'd0;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [31:0] EXC_NONE  = 32'd0;
  localparam logic [31:0] EXC_ECALL = 32'd1;
  localparam logic [31:0] EXC_MRET  = 32'd2;
  localparam logic [31:0] EXC_IRQ   = 32'd3;

  localparam logic [63:0] MCAUSE_ECALL = 64'd11;
  localparam logic [63:0] MCAUSE_IRQ   = {1'b1, 63'd7};

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIP_MTIP     = 7;

  localparam logic [63:0] MSTATUS_RESET = 64'h1800;

  typedef enum logic {
    ST_IDLE,
    ST_REDIRECT
  } state_e;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_IRQ,
    EV_ECALL,
    EV_MRET
  } event_e;

endpackage

// File: rtl/ysyx_210247_trap_if.sv
// Commit/redirect bundle between the pipeline and the trap unit.
// slave = trap unit side, master = pipeline side.
interface ysyx_210247_trap_if;
  import ysyx_210247_trap_pkg::*;

  logic               commit_valid;
  logic               commit_ready;
  logic [REG_BUS-1:0] commit_pc;
  logic               commit_ecall;
  logic               commit_mret;
  logic               csr_wen;
  logic [11:0]        csr_addr;
  logic [REG_BUS-1:0] csr_wdata;
  logic [REG_BUS-1:0] csr_rdata;
  logic               mtip;
  logic [31:0]        exc_op;
  logic [REG_BUS-1:0] csr_mepc;
  logic [REG_BUS-1:0] csr_mtvec;
  logic               redirect_ack;

  modport slave (
    input  commit_valid, commit_pc,
    input  commit_ecall, commit_mret,
    input  csr_wen, csr_addr, csr_wdata,
    input  mtip, redirect_ack,
    output commit_ready, csr_rdata,
    output exc_op, csr_mepc, csr_mtvec
  );

  modport master (
    output commit_valid, commit_pc,
    output commit_ecall, commit_mret,
    output csr_wen, csr_addr, csr_wdata,
    output mtip, redirect_ack,
    input  commit_ready, csr_rdata,
    input  exc_op, csr_mepc, csr_mtvec
  );

endinterface

// File: rtl/ysyx_210247_csr_file.sv
// Machine-mode CSRs and read mux for the trap unit.
// Trap/MRET updates take precedence over software writes.
module ysyx_210247_csr_file
  import ysyx_210247_trap_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wen,
  input  logic [11:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  input  logic        mtip,
  input  logic        trap,
  input  logic [63:0] trap_pc,
  input  logic [63:0] trap_cause,
  input  logic        mret,
  output logic [63:0] mepc_q,
  output logic [63:0] mtvec_q,
  output logic        mie_bit,
  output logic        mtie_bit
);

  logic        st_mie;
  logic        st_mpie;
  logic [63:0] mie_q;
  logic [63:0] mcause_q;
  logic [63:0] mstatus_rd;
  logic [63:0] mip_rd;

  assign mie_bit  = st_mie;
  assign mtie_bit = mie_q[MIE_MTIE];

  // Assemble the read views; MPP stays hardwired to M-mode.
  always_comb begin
    mstatus_rd = MSTATUS_RESET;
    mstatus_rd[MSTATUS_MIE]  = st_mie;
    mstatus_rd[MSTATUS_MPIE] = st_mpie;
    mip_rd = ZERO_WORD;
    mip_rd[MIP_MTIP] = mtip;
  end

  // Read mux sees pre-edge state; unimplemented CSRs read zero.
  always_comb begin
    rdata = ZERO_WORD;
    case (addr)
      CSR_MSTATUS: rdata = mstatus_rd;
      CSR_MIE:     rdata = mie_q;
      CSR_MTVEC:   rdata = mtvec_q;
      CSR_MEPC:    rdata = mepc_q;
      CSR_MCAUSE:  rdata = mcause_q;
      CSR_MIP:     rdata = mip_rd;
      default:     rdata = ZERO_WORD;
    endcase
  end

  // Register updates: trap entry, MRET, or a plain CSR write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      mie_q    <= ZERO_WORD;
      mtvec_q  <= ZERO_WORD;
      mepc_q   <= ZERO_WORD;
      mcause_q <= ZERO_WORD;
    end else if (trap) begin
      mepc_q   <= trap_pc;
      mcause_q <= trap_cause;
      st_mpie  <= st_mie;
      st_mie   <= 1'b0;
    end else if (mret) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (wen) begin
      case (addr)
        CSR_MSTATUS: begin
          st_mie  <= wdata[MSTATUS_MIE];
          st_mpie <= wdata[MSTATUS_MPIE];
        end
        CSR_MIE:    mie_q    <= wdata;
        CSR_MTVEC:  mtvec_q  <= {wdata[63:2], 2'b00};
        CSR_MEPC:   mepc_q   <= {wdata[63:2], 2'b00};
        CSR_MCAUSE: mcause_q <= wdata;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_210247_trap.sv
// Trap unit: picks one retire event and holds the redirect
// until fetch acknowledges it.
module ysyx_210247_trap
  import ysyx_210247_trap_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  ysyx_210247_trap_if.slave bus
);

  state_e      state;
  event_e      ev;
  logic [31:0] exc_q;
  logic        accept;
  logic        irq_take;
  logic        mie_bit;
  logic        mtie_bit;
  logic        ev_trap;
  logic        ev_mret;
  logic        wr_en;
  logic [63:0] cause;

  assign bus.commit_ready = (state == ST_IDLE);
  assign bus.exc_op       = exc_q;

  assign accept   = bus.commit_valid & bus.commit_ready;
  assign irq_take = accept & mie_bit & mtie_bit & bus.mtip;

  // Priority select: interrupt, then ECALL, then MRET.
  always_comb begin
    ev = EV_NONE;
    unique case (1'b1)
      irq_take:
        ev = EV_IRQ;
      accept & bus.commit_ecall & ~irq_take:
        ev = EV_ECALL;
      accept & bus.commit_mret & ~bus.commit_ecall & ~irq_take:
        ev = EV_MRET;
      default:
        ev = EV_NONE;
    endcase
  end

  assign ev_trap = (ev == EV_IRQ) | (ev == EV_ECALL);
  assign ev_mret = (ev == EV_MRET);
  assign wr_en   = accept & bus.csr_wen & (ev == EV_NONE);
  assign cause   = (ev == EV_IRQ) ? MCAUSE_IRQ : MCAUSE_ECALL;

  ysyx_210247_csr_file u_csr (
    .clk        (clk),
    .rst_n      (rst_n),
    .wen        (wr_en),
    .addr       (bus.csr_addr),
    .wdata      (bus.csr_wdata),
    .rdata      (bus.csr_rdata),
    .mtip       (bus.mtip),
    .trap       (ev_trap),
    .trap_pc    (bus.commit_pc),
    .trap_cause (cause),
    .mret       (ev_mret),
    .mepc_q     (bus.csr_mepc),
    .mtvec_q    (bus.csr_mtvec),
    .mie_bit    (mie_bit),
    .mtie_bit   (mtie_bit)
  );

  // Redirect FSM; ack only counts once the redirect is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      exc_q <= EXC_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          case (ev)
            EV_IRQ: begin
              exc_q <= EXC_IRQ;
              state <= ST_REDIRECT;
            end
            EV_ECALL: begin
              exc_q <= EXC_ECALL;
              state <= ST_REDIRECT;
            end
            EV_MRET: begin
              exc_q <= EXC_MRET;
              state <= ST_REDIRECT;
            end
            default: ;
          endcase
        end
        ST_REDIRECT: begin
          if (bus.redirect_ack) begin
            exc_q <= EXC_NONE;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_210247_trap.sv
// Scoreboard bench for ysyx_210247_trap.
// Expected redirects are queued at commit and popped on exc_op.
module tb_ysyx_210247_trap;
  import ysyx_210247_trap_pkg::*;

  typedef struct {
    logic [31:0] op;
    logic [63:0] pc;
    logic [63:0] cause;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb[$];

  ysyx_210247_trap_if bus ();

  ysyx_210247_trap dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic commit(input logic [63:0] pc, input bit ecall,
                        input bit mret, input bit wen,
                        input logic [11:0] addr,
                        input logic [63:0] wdata);
    bus.commit_valid = 1'b1;
    bus.commit_pc    = pc;
    bus.commit_ecall = ecall;
    bus.commit_mret  = mret;
    bus.csr_wen      = wen;
    bus.csr_addr     = addr;
    bus.csr_wdata    = wdata;
    @(posedge clk);
    #1;
    bus.commit_valid = 1'b0;
    bus.commit_ecall = 1'b0;
    bus.commit_mret  = 1'b0;
    bus.csr_wen      = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [63:0] d);
    bus.csr_addr = a;
    #1;
    d = bus.csr_rdata;
  endtask

  task automatic wait_exc(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.exc_op != 32'd0) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sb_pop(output exp_t e, output bit ok);
    ok = (sb.size() > 0);
    if (ok) e = sb.pop_front();
    else e = '{32'hx, 64'hx, 64'hx};
  endtask

  task automatic ack;
    bus.redirect_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.redirect_ack = 1'b0;
  endtask

  task automatic test_reset;
    logic [63:0] d;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    csr_read(CSR_MSTATUS, d);
    checks++;
    if (d !== 64'h1800) begin
      failures++;
      $display("FAIL reset_mstatus got=%h exp=%h", d, 64'h1800);
    end
    checks++;
    if (bus.exc_op !== EXC_NONE) begin
      failures++;
      $display("FAIL reset_exc_op got=%0d exp=0", bus.exc_op);
    end
    checks++;
    if (bus.commit_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", bus.commit_ready);
    end
  endtask

  task automatic test_ecall;
    logic [63:0] d;
    exp_t e;
    bit seen, ok;
    commit(64'h0, 0, 0, 1, CSR_MSTATUS, 64'h8);
    commit(64'h0, 0, 0, 1, CSR_MTVEC, 64'h8000_0103);
    csr_read(CSR_MTVEC, d);
    checks++;
    if (d !== 64'h8000_0100) begin
      failures++;
      $display("FAIL mtvec_align got=%h exp=%h", d, 64'h8000_0100);
    end
    checks++;
    if (bus.csr_mtvec !== 64'h8000_0100) begin
      failures++;
      $display("FAIL mtvec_port got=%h exp=%h", bus.csr_mtvec,
               64'h8000_0100);
    end
    sb.push_back('{EXC_ECALL, 64'h8000_0040, MCAUSE_ECALL});
    commit(64'h8000_0040, 1, 0, 0, 12'h0, 64'h0);
    checks++;
    if (bus.exc_op !== EXC_ECALL) begin
      failures++;
      $display("FAIL ecall_latency got=%0d exp=1", bus.exc_op);
    end
    wait_exc(seen);
    sb_pop(e, ok);
    checks++;
    if (!seen || !ok || bus.exc_op !== e.op || bus.csr_mepc !== e.pc) begin
      failures++;
      $display("FAIL ecall_sb op=%0d exp=%0d mepc=%h exp=%h",
               bus.exc_op, e.op, bus.csr_mepc, e.pc);
    end
    csr_read(CSR_MCAUSE, d);
    checks++;
    if (d !== e.cause) begin
      failures++;
      $display("FAIL ecall_mcause got=%h exp=%h", d, e.cause);
    end
    csr_read(CSR_MSTATUS, d);
    checks++;
    if (d !== 64'h1880) begin
      failures++;
      $display("FAIL ecall_mstatus got=%h exp=%h", d, 64'h1880);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.exc_op !== EXC_ECALL || bus.commit_ready !== 1'b0) begin
        failures++;
        $display("FAIL ecall_hold%0d op=%0d exp=1 ready=%b exp=0",
                 i, bus.exc_op, bus.commit_ready);
      end
      commit(64'h0, 0, 0, 1, CSR_MEPC, 64'h1234);
    end
    checks++;
    if (bus.csr_mepc !== 64'h8000_0040) begin
      failures++;
      $display("FAIL redirect_blocks_write got=%h exp=%h",
               bus.csr_mepc, 64'h8000_0040);
    end
    ack();
    checks++;
    if (bus.exc_op !== EXC_NONE || bus.commit_ready !== 1'b1) begin
      failures++;
      $display("FAIL ecall_ack op=%0d exp=0 ready=%b exp=1",
               bus.exc_op, bus.commit_ready);
    end
  endtask

  task automatic test_mret;
    logic [63:0] d;
    exp_t e;
    bit seen, ok;
    sb.push_back('{EXC_MRET, 64'h8000_0040, MCAUSE_ECALL});
    commit(64'h8000_0080, 0, 1, 0, 12'h0, 64'h0);
    wait_exc(seen);
    sb_pop(e, ok);
    checks++;
    if (!seen || !ok || bus.exc_op !== e.op || bus.csr_mepc !== e.pc) begin
      failures++;
      $display("FAIL mret_sb op=%0d exp=%0d mepc=%h exp=%h",
               bus.exc_op, e.op, bus.csr_mepc, e.pc);
    end
    csr_read(CSR_MSTATUS, d);
    checks++;
    if (d !== 64'h1888) begin
      failures++;
      $display("FAIL mret_mstatus got=%h exp=%h", d, 64'h1888);
    end
    ack();
  endtask

  task automatic test_irq;
    logic [63:0] d;
    exp_t e;
    bit seen, ok;
    commit(64'h0, 0, 0, 1, CSR_MIE, 64'h80);
    bus.mtip = 1'b1;
    sb.push_back('{EXC_IRQ, 64'h8000_0100, MCAUSE_IRQ});
    commit(64'h8000_0100, 1, 0, 1, CSR_MEPC, 64'hdead);
    wait_exc(seen);
    sb_pop(e, ok);
    checks++;
    if (!seen || !ok || bus.exc_op !== e.op || bus.csr_mepc !== e.pc) begin
      failures++;
      $display("FAIL irq_sb op=%0d exp=%0d mepc=%h exp=%h",
               bus.exc_op, e.op, bus.csr_mepc, e.pc);
    end
    csr_read(CSR_MCAUSE, d);
    checks++;
    if (d !== e.cause) begin
      failures++;
      $display("FAIL irq_mcause got=%h exp=%h", d, e.cause);
    end
    csr_read(CSR_MSTATUS, d);
    checks++;
    if (d !== 64'h1880) begin
      failures++;
      $display("FAIL irq_mstatus got=%h exp=%h", d, 64'h1880);
    end
    ack();
  endtask

  task automatic test_masked_irq;
    logic [63:0] d;
    commit(64'h8000_0200, 0, 0, 0, 12'h0, 64'h0);
    checks++;
    if (bus.exc_op !== EXC_NONE || bus.commit_ready !== 1'b1) begin
      failures++;
      $display("FAIL masked_irq op=%0d exp=0 ready=%b exp=1",
               bus.exc_op, bus.commit_ready);
    end
    csr_read(CSR_MIP, d);
    checks++;
    if (d !== 64'h80) begin
      failures++;
      $display("FAIL mip_read got=%h exp=%h", d, 64'h80);
    end
    bus.mtip = 1'b0;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    bit ok;
    bus.redirect_ack = 1'b1;
    sb.push_back('{EXC_ECALL, 64'h8000_0300, MCAUSE_ECALL});
    commit(64'h8000_0300, 1, 0, 0, 12'h0, 64'h0);
    sb_pop(e, ok);
    checks++;
    if (!ok || bus.exc_op !== e.op || bus.csr_mepc !== e.pc) begin
      failures++;
      $display("FAIL ack_on_load op=%0d exp=%0d mepc=%h exp=%h",
               bus.exc_op, e.op, bus.csr_mepc, e.pc);
    end
    @(posedge clk);
    #1;
    bus.redirect_ack = 1'b0;
    checks++;
    if (bus.exc_op !== EXC_NONE || bus.commit_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_clear op=%0d exp=0 ready=%b exp=1",
               bus.exc_op, bus.commit_ready);
    end
    sb.push_back('{EXC_ECALL, 64'h8000_0304, MCAUSE_ECALL});
    commit(64'h8000_0304, 1, 0, 0, 12'h0, 64'h0);
    sb_pop(e, ok);
    checks++;
    if (!ok || bus.exc_op !== e.op || bus.csr_mepc !== e.pc) begin
      failures++;
      $display("FAIL b2b_second op=%0d exp=%0d mepc=%h exp=%h",
               bus.exc_op, e.op, bus.csr_mepc, e.pc);
    end
    ack();
  endtask

  task automatic test_reset_mid;
    logic [63:0] d;
    exp_t e;
    bit seen, ok;
    sb.push_back('{EXC_ECALL, 64'h8000_0400, MCAUSE_ECALL});
    commit(64'h8000_0400, 1, 0, 0, 12'h0, 64'h0);
    wait_exc(seen);
    sb_pop(e, ok);
    checks++;
    if (!seen || !ok || bus.exc_op !== e.op) begin
      failures++;
      $display("FAIL pre_reset op=%0d exp=%0d", bus.exc_op, e.op);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.exc_op !== EXC_NONE) begin
      failures++;
      $display("FAIL async_reset_op got=%0d exp=0", bus.exc_op);
    end
    csr_read(CSR_MSTATUS, d);
    checks++;
    if (d !== 64'h1800 || bus.csr_mepc !== 64'h0 ||
        bus.csr_mtvec !== 64'h0) begin
      failures++;
      $display("FAIL async_reset_csr ms=%h mepc=%h mtvec=%h exp=1800/0/0",
               d, bus.csr_mepc, bus.csr_mtvec);
    end
    csr_read(CSR_MIE, d);
    checks++;
    if (d !== 64'h0) begin
      failures++;
      $display("FAIL async_reset_mie got=%h exp=0", d);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.exc_op !== EXC_NONE || bus.commit_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset op=%0d exp=0 ready=%b exp=1",
               bus.exc_op, bus.commit_ready);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.commit_valid = 1'b0;
    bus.commit_pc    = 64'h0;
    bus.commit_ecall = 1'b0;
    bus.commit_mret  = 1'b0;
    bus.csr_wen      = 1'b0;
    bus.csr_addr     = 12'h0;
    bus.csr_wdata    = 64'h0;
    bus.mtip         = 1'b0;
    bus.redirect_ack = 1'b0;
    test_reset();
    test_ecall();
    test_mret();
    test_irq();
    test_masked_irq();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
